// File: rtl/temp_alert_pkg.sv
// Shared types and helpers for the temperature alert conditioner.
package temp_alert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        ASRT = 2'd2,
        RELQ = 2'd3
    } state_t;

    // Debounce counter width; must hold 0..deb_cycles inclusive.
    function automatic int clog2_cnt(input int deb_cycles);
        return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
    endfunction

endpackage

// File: rtl/temp_alert_chan.sv
// One alert channel: input synchronisers, debounce FSM and sticky flag/miss logic.
// state | meaning
// IDLE  | sensor released, waiting for an assert
// QUAL  | assert seen, counting stable cycles
// ASRT  | assert qualified, ALERT_LVL high
// RELQ  | release seen, counting stable cycles
module temp_alert_chan
    import temp_alert_pkg::*;
#(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic alert_n,
    input  logic ack,
    output logic gpio_in,
    output logic alert_lvl,
    output logic missed
);

    localparam int CW = clog2_cnt(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]    alert_sync;
    logic [1:0]    ack_sync;
    logic          ack_d;
    logic          a;
    logic          ack_rise;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lvl_nxt;
    logic          set_ev;

    assign a        = ~alert_sync[1];
    assign ack_rise = ack_sync[1] & ~ack_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alert_sync <= 2'b11;
            ack_sync   <= 2'b00;
            ack_d      <= 1'b0;
        end else begin
            alert_sync <= {alert_sync[0], alert_n};
            ack_sync   <= {ack_sync[0], ack};
            ack_d      <= ack_sync[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            alert_lvl <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            alert_lvl <= lvl_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lvl_nxt   = alert_lvl;
        set_ev    = 1'b0;
        case (state)
            IDLE: begin
                if (a) begin
                    state_nxt = QUAL;
                    cnt_nxt   = CNT_ONE;
                end
            end
            QUAL: begin
                if (!a) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ASRT;
                    lvl_nxt   = 1'b1;
                    set_ev    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ASRT: begin
                if (!a) begin
                    state_nxt = RELQ;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELQ: begin
                if (a) begin
                    state_nxt = ASRT;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    lvl_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A set event beats a coincident ack; the miss only latches when no ack is racing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_in <= 1'b0;
            missed  <= 1'b0;
        end else if (set_ev) begin
            gpio_in <= 1'b1;
            if (gpio_in && !ack_rise) begin
                missed <= 1'b1;
            end
        end else if (ack_rise) begin
            gpio_in <= 1'b0;
            missed  <= 1'b0;
        end
    end

endmodule

// File: rtl/temp_alert_cond.sv
// Alert conditioner top: NCH independent debounced channels feeding sticky GPIO flags.
module temp_alert_cond #(
    parameter int NCH        = 2,
    parameter int DEB_CYCLES = 1000
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [NCH-1:0] ALERT_N,
    input  logic [NCH-1:0] ACK,
    output logic [NCH-1:0] GPIO_IN,
    output logic [NCH-1:0] ALERT_LVL,
    output logic [NCH-1:0] MISSED
);

    if (NCH < 1 || NCH > 8) begin : g_nch_check
        $error("temp_alert_cond: NCH must be in 1..8");
    end
    if (DEB_CYCLES < 1) begin : g_deb_check
        $error("temp_alert_cond: DEB_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        temp_alert_chan #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_chan (
            .clk      (CLK),
            .reset_n  (RESET_N),
            .alert_n  (ALERT_N[i]),
            .ack      (ACK[i]),
            .gpio_in  (GPIO_IN[i]),
            .alert_lvl(ALERT_LVL[i]),
            .missed   (MISSED[i])
        );
    end

endmodule

// File: tb/tb_temp_alert_cond.sv
// Directed bench for temp_alert_cond with DEB_CYCLES=4, NCH=2 (7-edge qualify, 3-edge ack).
module tb_temp_alert_cond;

    logic       CLK;
    logic       RESET_N;
    logic [1:0] ALERT_N;
    logic [1:0] ACK;
    logic [1:0] GPIO_IN;
    logic [1:0] ALERT_LVL;
    logic [1:0] MISSED;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [1:0] alert_n;
        logic [1:0] ack;
        int         cyc;
        logic [1:0] gpio;
        logic [1:0] lvl;
        logic [1:0] miss;
        string      name;
    } vec_t;

    vec_t vecs[$];

    temp_alert_cond #(
        .NCH       (2),
        .DEB_CYCLES(4)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .ALERT_N  (ALERT_N),
        .ACK      (ACK),
        .GPIO_IN  (GPIO_IN),
        .ALERT_LVL(ALERT_LVL),
        .MISSED   (MISSED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
        else n_pass++;
    endtask

    task automatic check_all(input string nm, input logic [1:0] g, input logic [1:0] l,
                             input logic [1:0] m);
        check({nm, "_gpio"}, GPIO_IN, g);
        check({nm, "_lvl"}, ALERT_LVL, l);
        check({nm, "_missed"}, MISSED, m);
    endtask

    function automatic void add(input logic [1:0] an, input logic [1:0] ak, input int cyc,
                                input logic [1:0] g, input logic [1:0] l, input logic [1:0] m,
                                input string nm);
        vec_t v;
        v.alert_n = an;
        v.ack     = ak;
        v.cyc     = cyc;
        v.gpio    = g;
        v.lvl     = l;
        v.miss    = m;
        v.name    = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //   alert_n ack    cyc  gpio   lvl    missed
        add(2'b11, 2'b00,  3, 2'b00, 2'b00, 2'b00, "idle");
        add(2'b10, 2'b00,  6, 2'b00, 2'b00, 2'b00, "t1_pre");
        add(2'b10, 2'b00,  1, 2'b01, 2'b01, 2'b00, "t1_edge7");
        add(2'b10, 2'b00, 13, 2'b01, 2'b01, 2'b00, "t1_hold");
        add(2'b00, 2'b00,  3, 2'b01, 2'b01, 2'b00, "t2_glitch3_low");
        add(2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b00, "t2_glitch3_after");
        add(2'b00, 2'b00,  4, 2'b01, 2'b01, 2'b00, "t2_glitch4_low");
        add(2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b00, "t2_glitch4_after");
        add(2'b11, 2'b00,  6, 2'b01, 2'b01, 2'b00, "t3_rel_pre");
        add(2'b11, 2'b00,  1, 2'b01, 2'b00, 2'b00, "t3_rel_edge7");
        add(2'b11, 2'b01,  2, 2'b01, 2'b00, 2'b00, "t3_ack_pre");
        add(2'b11, 2'b01,  1, 2'b00, 2'b00, 2'b00, "t3_ack_edge3");
        add(2'b11, 2'b01, 50, 2'b00, 2'b00, 2'b00, "t3_ack_held");
        add(2'b10, 2'b01,  7, 2'b01, 2'b01, 2'b00, "t3_set_ack_held");
        add(2'b10, 2'b01, 10, 2'b01, 2'b01, 2'b00, "t3_held_no_clear");
        add(2'b10, 2'b00,  3, 2'b01, 2'b01, 2'b00, "t3_ack_low");
        add(2'b11, 2'b00, 10, 2'b01, 2'b00, 2'b00, "t4_release");
        add(2'b10, 2'b00,  6, 2'b01, 2'b00, 2'b00, "t4_pre");
        add(2'b10, 2'b00,  1, 2'b01, 2'b01, 2'b01, "t4_missed");
        add(2'b10, 2'b01,  3, 2'b00, 2'b01, 2'b00, "t4_ack_clears");
        add(2'b10, 2'b00,  3, 2'b00, 2'b01, 2'b00, "t4_ack_low");
        add(2'b11, 2'b00, 10, 2'b00, 2'b00, 2'b00, "t5_release");
        add(2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b00, "t5_assert");
        add(2'b11, 2'b00, 10, 2'b01, 2'b00, 2'b00, "t5_release2");
        add(2'b10, 2'b00,  4, 2'b01, 2'b00, 2'b00, "t5_lead");
        add(2'b10, 2'b01,  3, 2'b01, 2'b01, 2'b00, "t5_simul");
        add(2'b10, 2'b01,  5, 2'b01, 2'b01, 2'b00, "t5_after");
        add(2'b10, 2'b00,  3, 2'b01, 2'b01, 2'b00, "t5_ack_low");
        add(2'b10, 2'b01,  3, 2'b00, 2'b01, 2'b00, "t5_ack_clear");
        add(2'b10, 2'b00,  3, 2'b00, 2'b01, 2'b00, "t5_ack_low2");
        add(2'b11, 2'b00, 10, 2'b00, 2'b00, 2'b00, "t6_prep_rel");
        add(2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b00, "t6_prep_set");
        add(2'b11, 2'b00, 10, 2'b01, 2'b00, 2'b00, "t6_prep_rel2");
        add(2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b01, "t6_prep_missed");

        RESET_N = 1'b0;
        ALERT_N = 2'b11;
        ACK     = 2'b00;
        #3;
        check_all("reset", 2'b00, 2'b00, 2'b00);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(1);

        foreach (vecs[i]) begin
            ALERT_N = vecs[i].alert_n;
            ACK     = vecs[i].ack;
            tick(vecs[i].cyc);
            check_all(vecs[i].name, vecs[i].gpio, vecs[i].lvl, vecs[i].miss);
        end

        // Channel 1 enters QUAL and reaches cnt=3; reset hits mid-cycle.
        ALERT_N = 2'b00;
        tick(5);
        check_all("t6_qual", 2'b01, 2'b01, 2'b01);
        #2;
        RESET_N = 1'b0;
        #1;
        check_all("t6_async_reset", 2'b00, 2'b00, 2'b00);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick(6);
        check_all("t6_restart_pre", 2'b00, 2'b00, 2'b00);
        tick(1);
        check_all("t6_restart_edge7", 2'b11, 2'b11, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
